regfile_writeback: RTL and testbench

- Write-side front end for the 1024x64 register file: collects results from the ALU and the load unit, arbitrates them onto the file's single write port (we/waddr/wdata), and forwards in-flight values to the decode-stage read addresses.
- Each source owns a one-entry holding slot; a registered output stage drives the file.
- Register 0 is never written and never forwarded.

---
 rtl/regfile_pkg.sv | 55 +++++
 rtl/wb_slot.sv | 56 +++++
 rtl/regfile_writeback.sv | 155 +++++++++++++++
 tb/tb_regfile_writeback.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back front end.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package regfile_pkg;

  // Default geometry of the register file: 1024 entries of 64 bits.
  localparam int RF_ADDR_W = 10;
  localparam int RF_DATA_W = 64;

  // Register 0 is hardwired: never written, never forwarded.
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

  // One pending register write: destination and value.
  // Used for both holding slots and for the registered output stage.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

  // Result of a forwarding lookup for one decode read port.
  typedef struct packed {
    logic                 hit;
    logic [RF_DATA_W-1:0] data;
  } fwd_t;

  // Priority lookup over the three places a pending write can live.
  // Candidates are searched youngest first so the most recent value for a
  // register wins when several pending writes target it.
  function automatic fwd_t fwd_lookup(
    input logic [RF_ADDR_W-1:0] ra,
    input logic                 young_vld,
    input wb_entry_t            young,
    input logic                 old_vld,
    input wb_entry_t            old,
    input logic                 stage_vld,
    input wb_entry_t            stage
  );
    fwd_t r;
    r = '0;
    if (ra != REG_ZERO) begin
      if (young_vld && (young.rd == ra)) begin
        r.hit  = 1'b1;
        r.data = young.data;
      end else if (old_vld && (old.rd == ra)) begin
        r.hit  = 1'b1;
        r.data = old.data;
      end else if (stage_vld && (stage.rd == ra)) begin
        r.hit  = 1'b1;
        r.data = stage.data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a single write-back source.
// Latency: accepted entry is visible on full_o/entry_o the cycle after the accepting edge.
// Backpressure: ready while empty or while being drained this cycle; forced low during reset.
module wb_slot
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid_i,
  output logic      in_ready_o,
  input  wb_entry_t in_entry_i,
  input  logic      drain_i,
  output logic      full_o,
  output wb_entry_t entry_o
);

  logic      full_q, full_d;
  wb_entry_t entry_q, entry_d;
  logic      accept;
  logic      keep;

  // A slot being drained this cycle can take a new entry at the same edge,
  // which gives one acceptance per cycle under continuous grant.
  assign in_ready_o = rst_n & (~full_q | drain_i);
  assign accept     = in_valid_i & in_ready_o;
  // Writes to register 0 complete the handshake but are discarded here.
  assign keep       = accept & (in_entry_i.rd != REG_ZERO);

  // Next-state: refill on a kept accept, otherwise empty on drain.
  always_comb begin
    full_d  = keep | (full_q & ~drain_i);
    entry_d = keep ? in_entry_i : entry_q;
  end

  // Slot storage; reset drops any held entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full_o  = full_q;
  assign entry_o = entry_q;

  // A producer that is stalled must keep its request unchanged.
  property p_hold_stable;
    @(posedge clk) disable iff (!rst_n)
      (in_valid_i && !in_ready_o) |=> (in_valid_i && $stable(in_entry_i));
  endproperty
  a_hold_stable: assert property (p_hold_stable);

endmodule

// File: rtl/regfile_writeback.sv
// Write-back front end: ALU and load results arbitrate, oldest first, onto the single register-file write port.
// Latency: accept at edge N, slot granted in cycle N..N+1, we high in N+1..N+2, file written at edge N+2.
// Backpressure: each source's ready is low only while its slot is full and not granted this cycle.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd2_data
);

  wb_entry_t alu_in, mem_in;
  wb_entry_t alu_ent, mem_ent;
  logic      alu_full, mem_full;
  logic      alu_gnt, mem_gnt, gnt_any;
  wb_entry_t gnt_ent;

  // Age order between the two slots: 1 means the ALU slot holds the older
  // entry. Only meaningful while both slots are full.
  logic      alu_older_q, alu_older_d;

  // Registered output stage driving the file's write port.
  logic      we_q, we_d;
  wb_entry_t out_q, out_d;

  // Forwarding candidates ordered by age.
  logic      young_vld, old_vld;
  wb_entry_t young_ent, old_ent;
  fwd_t      fwd1, fwd2;

  assign alu_in = {alu_rd, alu_data};
  assign mem_in = {mem_rd, mem_data};

  wb_slot u_alu_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (alu_valid),
    .in_ready_o (alu_ready),
    .in_entry_i (alu_in),
    .drain_i    (alu_gnt),
    .full_o     (alu_full),
    .entry_o    (alu_ent)
  );

  wb_slot u_mem_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (mem_valid),
    .in_ready_o (mem_ready),
    .in_entry_i (mem_in),
    .drain_i    (mem_gnt),
    .full_o     (mem_full),
    .entry_o    (mem_ent)
  );

  // Oldest-first grant; a lone full slot is granted unconditionally.
  always_comb begin
    alu_gnt = alu_full & (~mem_full | alu_older_q);
    mem_gnt = mem_full & (~alu_full | ~alu_older_q);
    gnt_any = alu_gnt | mem_gnt;
    gnt_ent = alu_gnt ? alu_ent : mem_ent;
  end

  // Age update. A slot that stays full without being granted is older than
  // anything that arrives alongside it. Otherwise both entries, if any, are
  // new at this edge, and a same-edge pair orders mem before alu, which the
  // zero value here encodes. Since at most one slot is granted per cycle,
  // at most one slot can be retained.
  always_comb begin
    alu_older_d = alu_full & ~alu_gnt;
  end

  // Age register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_older_q <= 1'b0;
    end else begin
      alu_older_q <= alu_older_d;
    end
  end

  // Output stage next-state: capture the granted entry, else idle with the
  // address and data held.
  always_comb begin
    we_d  = gnt_any;
    out_d = gnt_any ? gnt_ent : out_q;
  end

  // Output stage register; reset pulls the write enable low immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      out_q <= '0;
    end else begin
      we_q  <= we_d;
      out_q <= out_d;
    end
  end

  assign we    = we_q;
  assign waddr = out_q.rd;
  assign wdata = out_q.data;

  // Order the slots for forwarding. With one slot empty its valid is low,
  // so the order chosen does not matter.
  always_comb begin
    if (alu_older_q) begin
      young_vld = mem_full;
      young_ent = mem_ent;
      old_vld   = alu_full;
      old_ent   = alu_ent;
    end else begin
      young_vld = alu_full;
      young_ent = alu_ent;
      old_vld   = mem_full;
      old_ent   = mem_ent;
    end
  end

  // Forwarding lookups for both decode read ports. A slot granted this
  // cycle is still searched here and appears in the output stage next
  // cycle, so a pending value is never invisible.
  always_comb begin
    fwd1 = fwd_lookup(ra1, young_vld, young_ent, old_vld, old_ent, we_q, out_q);
    fwd2 = fwd_lookup(ra2, young_vld, young_ent, old_vld, old_ent, we_q, out_q);
  end

  assign fwd1_hit  = fwd1.hit;
  assign fwd1_data = fwd1.data;
  assign fwd2_hit  = fwd2.hit;
  assign fwd2_data = fwd2.data;

  // The two grants are mutually exclusive.
  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(alu_gnt && mem_gnt));

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [9:0]  alu_rd, mem_rd, ra1, ra2, waddr;
  logic [63:0] alu_data, mem_data, wdata, fwd1_data, fwd2_data;
  logic        we, fwd1_hit, fwd2_hit;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .ra1       (ra1),
    .ra2       (ra2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic av; logic [9:0] ard; logic [63:0] ad;
    logic mv; logic [9:0] mrd; logic [63:0] md;
    logic [9:0] r1; logic [9:0] r2;
    logic e_ar; logic e_mr; logic e_we; logic [9:0] e_wa; logic [63:0] e_wd;
    logic e_h1; logic [63:0] e_d1; logic e_h2; logic [63:0] e_d2;
  } vec_t;

  localparam logic [63:0] DB = 64'hDEAD_BEEF;
  localparam logic [63:0] VA = 64'hA;
  localparam logic [63:0] VB = 64'hB;
  localparam logic [63:0] Z  = 64'h0;
  localparam logic [63:0] V1234 = 64'h1234;

  vec_t tbl [10];

  // ---------------- reference model ----------------
  // Each source holds at most one pending write stamped with its arrival
  // order; the oldest stamp retires first; the youngest matching stamp is
  // what a reader should see.
  typedef struct {
    bit          full;
    int unsigned ts;
    logic [9:0]  rd;
    logic [63:0] d;
  } pend_t;

  pend_t       m_src [2];   // 0 = load unit, 1 = ALU
  bit          m_we;
  logic [9:0]  m_waddr;
  logic [63:0] m_wdata;
  int unsigned ts_cnt;
  int          gsel;
  bit          e_ar, e_mr, e_h1, e_h2;
  logic [63:0] e_d1, e_d2;
  logic [63:0] model_file [1024];
  logic [63:0] dut_file [1024];
  bit          alu_hold, mem_hold;

  task automatic model_fwd(input logic [9:0] ra, output bit h, output logic [63:0] d);
    int best;
    h = 1'b0;
    d = '0;
    best = -1;
    if (ra != 10'd0) begin
      for (int s = 0; s < 2; s++)
        if (m_src[s].full && m_src[s].rd == ra && (best < 0 || m_src[s].ts > m_src[best].ts))
          best = s;
      if (best >= 0) begin
        h = 1'b1;
        d = m_src[best].d;
      end else if (m_we && m_waddr == ra) begin
        h = 1'b1;
        d = m_wdata;
      end
    end
  endtask

  task automatic model_eval();
    gsel = -1;
    for (int s = 0; s < 2; s++)
      if (m_src[s].full && (gsel < 0 || m_src[s].ts < m_src[gsel].ts))
        gsel = s;
    e_mr = !m_src[0].full || gsel == 0;
    e_ar = !m_src[1].full || gsel == 1;
    model_fwd(ra1, e_h1, e_d1);
    model_fwd(ra2, e_h2, e_d2);
  endtask

  task automatic model_step();
    bit acc_m, acc_a;
    acc_m = mem_valid && e_mr;
    acc_a = alu_valid && e_ar;
    if (m_we) model_file[m_waddr] = m_wdata;
    if (gsel >= 0) begin
      m_we    = 1'b1;
      m_waddr = m_src[gsel].rd;
      m_wdata = m_src[gsel].d;
      m_src[gsel].full = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (acc_m && mem_rd != 10'd0) begin
      m_src[0].full = 1'b1; m_src[0].ts = ts_cnt; m_src[0].rd = mem_rd; m_src[0].d = mem_data;
      ts_cnt++;
    end
    if (acc_a && alu_rd != 10'd0) begin
      m_src[1].full = 1'b1; m_src[1].ts = ts_cnt; m_src[1].rd = alu_rd; m_src[1].d = alu_data;
      ts_cnt++;
    end
  endtask

  function automatic logic [9:0] rnd_rd();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 10'd0;
    if (r < 12) return 10'(r % 6 + 1);
    return 10'($urandom_range(1, 1023));
  endfunction

  task automatic run_cycle(input bit allow_new);
    @(negedge clk);
    if (!alu_hold) begin
      alu_valid = allow_new && ($urandom_range(0, 9) < 7);
      alu_rd    = rnd_rd();
      alu_data  = {$urandom, $urandom};
    end
    if (!mem_hold) begin
      mem_valid = allow_new && ($urandom_range(0, 9) < 7);
      mem_rd    = rnd_rd();
      mem_data  = {$urandom, $urandom};
    end
    ra1 = 10'($urandom_range(0, 7));
    ra2 = ($urandom_range(0, 3) == 0) ? alu_rd : 10'($urandom_range(0, 7));
    #1;
    model_eval();
    chk("rnd_alu_ready", 64'(alu_ready), 64'(e_ar));
    chk("rnd_mem_ready", 64'(mem_ready), 64'(e_mr));
    chk("rnd_we",        64'(we),        64'(m_we));
    chk("rnd_waddr",     64'(waddr),     64'(m_waddr));
    chk("rnd_wdata",     wdata,          m_wdata);
    chk("rnd_fwd1_hit",  64'(fwd1_hit),  64'(e_h1));
    chk("rnd_fwd1_data", fwd1_data,      e_d1);
    chk("rnd_fwd2_hit",  64'(fwd2_hit),  64'(e_h2));
    chk("rnd_fwd2_data", fwd2_data,      e_d2);
    if (we) dut_file[waddr] = wdata;
    alu_hold = alu_valid && !e_ar;
    mem_hold = mem_valid && !e_mr;
    model_step();
  endtask

  initial begin
    int mism;
    // av ard ad | mv mrd md | r1 r2 | e_ar e_mr e_we e_wa e_wd | e_h1 e_d1 | e_h2 e_d2
    tbl[0] = '{1'b1, 10'd5, DB, 1'b0, 10'd0, Z,     10'd5, 10'd0, 1'b1, 1'b1, 1'b0, 10'd0, Z,  1'b0, Z,  1'b0, Z};
    tbl[1] = '{1'b0, 10'd0, Z,  1'b0, 10'd0, Z,     10'd5, 10'd0, 1'b1, 1'b1, 1'b0, 10'd0, Z,  1'b1, DB, 1'b0, Z};
    tbl[2] = '{1'b0, 10'd0, Z,  1'b0, 10'd0, Z,     10'd5, 10'd5, 1'b1, 1'b1, 1'b1, 10'd5, DB, 1'b1, DB, 1'b1, DB};
    tbl[3] = '{1'b0, 10'd0, Z,  1'b1, 10'd0, V1234, 10'd0, 10'd5, 1'b1, 1'b1, 1'b0, 10'd5, DB, 1'b0, Z,  1'b0, Z};
    tbl[4] = '{1'b0, 10'd0, Z,  1'b0, 10'd0, Z,     10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 10'd5, DB, 1'b0, Z,  1'b0, Z};
    tbl[5] = '{1'b1, 10'd3, VA, 1'b1, 10'd3, VB,    10'd3, 10'd3, 1'b1, 1'b1, 1'b0, 10'd5, DB, 1'b0, Z,  1'b0, Z};
    tbl[6] = '{1'b0, 10'd0, Z,  1'b0, 10'd0, Z,     10'd3, 10'd3, 1'b0, 1'b1, 1'b0, 10'd5, DB, 1'b1, VA, 1'b1, VA};
    tbl[7] = '{1'b0, 10'd0, Z,  1'b0, 10'd0, Z,     10'd3, 10'd5, 1'b1, 1'b1, 1'b1, 10'd3, VB, 1'b1, VA, 1'b0, Z};
    tbl[8] = '{1'b0, 10'd0, Z,  1'b0, 10'd0, Z,     10'd3, 10'd3, 1'b1, 1'b1, 1'b1, 10'd3, VA, 1'b1, VA, 1'b1, VA};
    tbl[9] = '{1'b0, 10'd0, Z,  1'b0, 10'd0, Z,     10'd3, 10'd0, 1'b1, 1'b1, 1'b0, 10'd3, VA, 1'b0, Z,  1'b0, Z};

    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    ra1 = '0; ra2 = '0;
    alu_hold = 1'b0; mem_hold = 1'b0;

    // Reset state
    #2;
    chk("rst_we",        64'(we),        64'd0);
    chk("rst_waddr",     64'(waddr),     64'd0);
    chk("rst_wdata",     wdata,          64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: single write, zero register, same-rd pair
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
      mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].md;
      ra1 = tbl[i].r1; ra2 = tbl[i].r2;
      #1;
      chk($sformatf("tbl%0d_alu_ready", i), 64'(alu_ready), 64'(tbl[i].e_ar));
      chk($sformatf("tbl%0d_mem_ready", i), 64'(mem_ready), 64'(tbl[i].e_mr));
      chk($sformatf("tbl%0d_we", i),        64'(we),        64'(tbl[i].e_we));
      chk($sformatf("tbl%0d_waddr", i),     64'(waddr),     64'(tbl[i].e_wa));
      chk($sformatf("tbl%0d_wdata", i),     wdata,          tbl[i].e_wd);
      chk($sformatf("tbl%0d_fwd1_hit", i),  64'(fwd1_hit),  64'(tbl[i].e_h1));
      chk($sformatf("tbl%0d_fwd1_data", i), fwd1_data,      tbl[i].e_d1);
      chk($sformatf("tbl%0d_fwd2_hit", i),  64'(fwd2_hit),  64'(tbl[i].e_h2));
      chk($sformatf("tbl%0d_fwd2_data", i), fwd2_data,      tbl[i].e_d2);
    end

    // Async reset with both slots full and a write in the output stage
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 10'd9;  alu_data = 64'h9999;
    mem_valid = 1'b1; mem_rd = 10'd10; mem_data = 64'h1010;
    ra1 = 10'd9; ra2 = 10'd10;
    @(negedge clk);
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 10'd11; mem_data = 64'h1111;
    #1;
    chk("pre_rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("pre_rst_mem_ready", 64'(mem_ready), 64'd1);
    @(posedge clk);
    #1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("pre_rst_we",        64'(we),       64'd1);
    chk("pre_rst_waddr",     64'(waddr),    64'd10);
    chk("pre_rst_fwd1_data", fwd1_data,     64'h9999);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",        64'(we),        64'd0);
    chk("mid_rst_waddr",     64'(waddr),     64'd0);
    chk("mid_rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("mid_rst_mem_ready", 64'(mem_ready), 64'd0);
    chk("mid_rst_fwd1_hit",  64'(fwd1_hit),  64'd0);
    chk("mid_rst_fwd2_hit",  64'(fwd2_hit),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d_we", i),       64'(we),        64'd0);
      chk($sformatf("post_rst%0d_fwd1", i),     64'(fwd1_hit),  64'd0);
      chk($sformatf("post_rst%0d_alu_rdy", i),  64'(alu_ready), 64'd1);
    end

    // Randomized traffic against the reference model
    for (int s = 0; s < 2; s++) begin
      m_src[s].full = 1'b0; m_src[s].ts = 0; m_src[s].rd = '0; m_src[s].d = '0;
    end
    m_we = 1'b0; m_waddr = '0; m_wdata = '0; ts_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      model_file[i] = '0;
      dut_file[i]   = '0;
    end
    for (int c = 0; c < 400; c++) run_cycle(1'b1);
    for (int c = 0; c < 10; c++)  run_cycle(1'b0);

    mism = 0;
    for (int i = 0; i < 1024; i++)
      if (dut_file[i] !== model_file[i]) mism++;
    chk("regfile_contents_mismatches", 64'(mism), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
